// File: rtl/qoi_axis_frame_arbiter.sv
// Two-port frame-locked round-robin arbiter sharing one 32-bit AXI-stream output.
// Latency: 1 cycle input-to-output; one idle arbitration cycle between frames.
// Backpressure: granted port's tready = ~o_tvalid | o_tready; the other port sees tready = 0.
//
// Ports:
//   clk, rst                                  clock and async active-high reset
//   i0_* / i1_*  (tvalid/tready/tdata/tkeep/tlast) requester AXI-stream slaves
//   o_*          (tvalid/tready/tdata/tkeep/tlast) shared AXI-stream master, o_src = beat origin
//   o_frame_done/o_frame_src/o_frame_bytes     one-cycle report per finished output frame
module qoi_axis_frame_arbiter #(
    parameter bit INIT_PRIO = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             i0_tready,
    input  logic             i0_tvalid,
    input  logic [31:0]      i0_tdata,
    input  logic [3:0]       i0_tkeep,
    input  logic             i0_tlast,
    output logic             i1_tready,
    input  logic             i1_tvalid,
    input  logic [31:0]      i1_tdata,
    input  logic [3:0]       i1_tkeep,
    input  logic             i1_tlast,
    input  logic             o_tready,
    output logic             o_tvalid,
    output logic [31:0]      o_tdata,
    output logic [3:0]       o_tkeep,
    output logic             o_tlast,
    output logic             o_src,
    output logic             o_frame_done,
    output logic             o_frame_src,
    output logic [CNT_W-1:0] o_frame_bytes
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               pref_q, pref_d;

    logic               o_tvalid_q;
    logic [31:0]        o_tdata_q;
    logic [3:0]         o_tkeep_q;
    logic               o_tlast_q;
    logic               o_src_q;

    logic               frame_done_q;
    logic               frame_src_q;
    logic [CNT_W-1:0]   frame_bytes_q;
    logic [CNT_W-1:0]   acc_q;

    logic               out_free;
    logic               in_acc0, in_acc1, in_acc;
    logic [31:0]        sel_data;
    logic [3:0]         sel_keep;
    logic               sel_last;
    logic               out_hs;
    logic [2:0]         beat_bytes;
    logic [CNT_W-1:0]   acc_sum;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = ~o_tvalid_q | o_tready;

    assign in_acc0 = (state_q == ST_BUSY0) & i0_tvalid & out_free;
    assign in_acc1 = (state_q == ST_BUSY1) & i1_tvalid & out_free;
    assign in_acc  = in_acc0 | in_acc1;

    assign sel_data = in_acc1 ? i1_tdata : i0_tdata;
    assign sel_keep = in_acc1 ? i1_tkeep : i0_tkeep;
    assign sel_last = in_acc1 ? i1_tlast : i0_tlast;

    always_comb begin
        state_d   = state_q;
        pref_d    = pref_q;
        i0_tready = 1'b0;
        i1_tready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Arbitration cycle: no data accepted, only the grant decision.
                if (i0_tvalid && i1_tvalid) begin
                    state_d = pref_q ? ST_BUSY1 : ST_BUSY0;
                end else if (i0_tvalid) begin
                    state_d = ST_BUSY0;
                end else if (i1_tvalid) begin
                    state_d = ST_BUSY1;
                end
            end
            ST_BUSY0: begin
                i0_tready = out_free;
                if (in_acc0 && i0_tlast) begin
                    state_d = ST_IDLE;
                    pref_d  = 1'b1;
                end
            end
            ST_BUSY1: begin
                i1_tready = out_free;
                if (in_acc1 && i1_tlast) begin
                    state_d = ST_IDLE;
                    pref_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pref_q  <= INIT_PRIO;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
        end
    end

    // Output stage: fields only change on a load, so they stay put while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tkeep_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_src_q    <= 1'b0;
        end else if (in_acc) begin
            o_tvalid_q <= 1'b1;
            o_tdata_q  <= sel_data;
            o_tkeep_q  <= sel_keep;
            o_tlast_q  <= sel_last;
            o_src_q    <= in_acc1;
        end else if (o_tready) begin
            o_tvalid_q <= 1'b0;
        end
    end

    // Bytes are counted as they leave, so the report matches what the sink saw.
    assign out_hs     = o_tvalid_q & o_tready;
    assign beat_bytes = 3'(o_tkeep_q[0]) + 3'(o_tkeep_q[1]) + 3'(o_tkeep_q[2]) + 3'(o_tkeep_q[3]);
    assign acc_sum    = acc_q + CNT_W'(beat_bytes);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            frame_done_q  <= 1'b0;
            frame_src_q   <= 1'b0;
            frame_bytes_q <= '0;
        end else begin
            frame_done_q <= out_hs & o_tlast_q;
            if (out_hs) begin
                if (o_tlast_q) begin
                    frame_bytes_q <= acc_sum;
                    frame_src_q   <= o_src_q;
                    acc_q         <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign o_tvalid      = o_tvalid_q;
    assign o_tdata       = o_tdata_q;
    assign o_tkeep       = o_tkeep_q;
    assign o_tlast       = o_tlast_q;
    assign o_src         = o_src_q;
    assign o_frame_done  = frame_done_q;
    assign o_frame_src   = frame_src_q;
    assign o_frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_qoi_axis_frame_arbiter.sv
// Directed bench for qoi_axis_frame_arbiter with a beat/frame scoreboard.
// Port drivers and output monitor run in the background; the main sequence feeds them.
// Output stalls come from a per-cycle o_tready pattern queue (default ready).
module tb_qoi_axis_frame_arbiter;

    typedef struct packed {
        logic        src;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        src;
        logic [31:0] bytes;
    } frm_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i0_tready, i1_tready;
    logic        i0_tvalid = 1'b0, i1_tvalid = 1'b0;
    logic [31:0] i0_tdata = '0, i1_tdata = '0;
    logic [3:0]  i0_tkeep = '0, i1_tkeep = '0;
    logic        i0_tlast = 1'b0, i1_tlast = 1'b0;
    logic        o_tready = 1'b1;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    logic        o_src;
    logic        o_frame_done;
    logic        o_frame_src;
    logic [31:0] o_frame_bytes;

    qoi_axis_frame_arbiter #(.INIT_PRIO(1'b0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i0_tready(i0_tready), .i0_tvalid(i0_tvalid), .i0_tdata(i0_tdata),
        .i0_tkeep(i0_tkeep), .i0_tlast(i0_tlast),
        .i1_tready(i1_tready), .i1_tvalid(i1_tvalid), .i1_tdata(i1_tdata),
        .i1_tkeep(i1_tkeep), .i1_tlast(i1_tlast),
        .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
        .o_tkeep(o_tkeep), .o_tlast(o_tlast), .o_src(o_src),
        .o_frame_done(o_frame_done), .o_frame_src(o_frame_src),
        .o_frame_bytes(o_frame_bytes)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    stall_seen = 0;
    beat_t p0_q[$], p1_q[$], exp_q[$];
    frm_t  expf_q[$];
    logic  rpat[$];
    int    acc0_cyc[$], acc1_cyc[$], ohs_cyc[$];
    int    bytes0 = 0, bytes1 = 0;
    logic  h0, h1;
    logic  prev_stall = 1'b0;
    beat_t prev_beat, cur_beat, e_beat;
    frm_t  e_frm;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: every pushed beat is expected at the output in push order,
    // and each tlast closes a frame whose byte count is the sum of tkeep popcounts.
    task automatic push_beat(input logic port, input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.src = port; b.data = d; b.keep = k; b.last = l;
        if (port) p1_q.push_back(b); else p0_q.push_back(b);
        exp_q.push_back(b);
        if (port) bytes1 += $countones(k); else bytes0 += $countones(k);
        if (l) begin
            frm_t f;
            f.src   = port;
            f.bytes = port ? 32'(bytes1) : 32'(bytes0);
            expf_q.push_back(f);
            if (port) bytes1 = 0; else bytes0 = 0;
        end
    endtask

    task automatic clear_model();
        p0_q.delete(); p1_q.delete(); exp_q.delete(); expf_q.delete(); rpat.delete();
        bytes0 = 0; bytes1 = 0;
        i0_tvalid = 1'b0; i1_tvalid = 1'b0; o_tready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc0_cyc.delete(); acc1_cyc.delete(); ohs_cyc.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((p0_q.size() + p1_q.size() + exp_q.size() + expf_q.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 500), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Port drivers: a handshake seen at the edge retires the head beat, then the
    // next head beat (if any) is presented.
    always @(posedge clk) begin
        cyc++;
        h0 = i0_tvalid && i0_tready;
        h1 = i1_tvalid && i1_tready;
        if (h0) acc0_cyc.push_back(cyc);
        if (h1) acc1_cyc.push_back(cyc);
        #1;
        if (h0 && p0_q.size() != 0) void'(p0_q.pop_front());
        if (h1 && p1_q.size() != 0) void'(p1_q.pop_front());
        if (p0_q.size() != 0) begin
            i0_tvalid = 1'b1; i0_tdata = p0_q[0].data; i0_tkeep = p0_q[0].keep; i0_tlast = p0_q[0].last;
        end else begin
            i0_tvalid = 1'b0;
        end
        if (p1_q.size() != 0) begin
            i1_tvalid = 1'b1; i1_tdata = p1_q[0].data; i1_tkeep = p1_q[0].keep; i1_tlast = p1_q[0].last;
        end else begin
            i1_tvalid = 1'b0;
        end
        if (rpat.size() != 0) o_tready = rpat.pop_front();
        else o_tready = 1'b1;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur_beat.src = o_src; cur_beat.data = o_tdata; cur_beat.keep = o_tkeep; cur_beat.last = o_tlast;
            if (prev_stall) begin
                stall_seen++;
                check("stall_hold", 64'({o_tvalid, cur_beat}), 64'({1'b1, prev_beat}));
            end
            if (o_tvalid && !o_tready)
                check("stall_in_tready", 64'({i0_tready, i1_tready}), 64'd0);
            prev_stall = o_tvalid && !o_tready;
            prev_beat  = cur_beat;
            if (o_tvalid && o_tready) begin
                ohs_cyc.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(cur_beat), 64'd0);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat", 64'(cur_beat), 64'(e_beat));
                end
            end
            if (o_frame_done) begin
                if (expf_q.size() == 0) begin
                    check("frame_done_unexpected", 64'd1, 64'd0);
                end else begin
                    e_frm = expf_q.pop_front();
                    check("frame_report", 64'({o_frame_src, o_frame_bytes}), 64'(e_frm));
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_out", 64'({o_tvalid, o_tdata, o_tkeep, o_tlast, o_src}), 64'd0);
        check("rst_frame", 64'({o_frame_done, o_frame_src, o_frame_bytes, i0_tready, i1_tready}), 64'd0);
        do_reset();

        // Single 3-beat frame on port 0, 9 bytes
        push_beat(1'b0, 32'h04030201, 4'hF, 1'b0);
        push_beat(1'b0, 32'h08070605, 4'hF, 1'b0);
        push_beat(1'b0, 32'h0000000A, 4'h1, 1'b1);
        drain("t1_drain");
        check("t1_nbeats", 64'(ohs_cyc.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < ohs_cyc.size() && i < acc0_cyc.size())
                check("t1_latency", 64'(ohs_cyc[i] - acc0_cyc[i]), 64'd1);

        // Both ports continuously valid: order 0,1,0,1 with one bubble between frames
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 2; b++)
                    push_beat(p[0], 32'hA0000000 | (p << 16) | (f << 8) | b, 4'hF, b == 1);
        end
        drain("t2_drain");
        check("t2_nbeats", 64'(ohs_cyc.size()), 64'd8);
        for (int i = 1; i < 8; i++)
            if (i < ohs_cyc.size())
                check("t2_gap", 64'(ohs_cyc[i] - ohs_cyc[i-1]), (i % 2 == 1) ? 64'd1 : 64'd2);

        // Backpressure during a port-1 frame
        do_reset();
        stall_seen = 0;
        for (int b = 0; b < 4; b++)
            push_beat(1'b1, 32'hB0B0_0000 + 32'(b), 4'hF, b == 3);
        n = 0;
        while (!o_tvalid && n < 50) begin @(negedge clk); n++; end
        check("t3_first_valid", 64'(o_tvalid), 64'd1);
        rpat.push_back(1'b0); rpat.push_back(1'b0); rpat.push_back(1'b1);
        rpat.push_back(1'b0); rpat.push_back(1'b0); rpat.push_back(1'b1);
        drain("t3_drain");
        check("t3_stall_seen", 64'(stall_seen != 0), 64'd1);

        // Port 1 requests while port 0 is mid-frame
        do_reset();
        push_beat(1'b0, 32'hC0000001, 4'hF, 1'b0);
        push_beat(1'b0, 32'hC0000002, 4'hF, 1'b0);
        push_beat(1'b0, 32'hC0000003, 4'h3, 1'b1);
        n = 0;
        while (acc0_cyc.size() < 1 && n < 50) begin @(posedge clk); #2; n++; end
        push_beat(1'b1, 32'hD0000001, 4'hF, 1'b0);
        push_beat(1'b1, 32'hD0000002, 4'h7, 1'b1);
        n = 0;
        while (acc0_cyc.size() < 3 && n < 50) begin
            @(negedge clk);
            check("t4_i1_blocked", 64'(i1_tready), 64'd0);
            n++;
        end
        drain("t4_drain");
        check("t4_n_acc1", 64'(acc1_cyc.size()), 64'd2);
        if (acc1_cyc.size() > 0 && acc0_cyc.size() > 2)
            check("t4_idle_gap", 64'(acc1_cyc[0] - acc0_cyc[2]), 64'd2);

        // tlast with tkeep = 0
        do_reset();
        push_beat(1'b0, 32'hE0E0E0E0, 4'hF, 1'b0);
        push_beat(1'b0, 32'h12345678, 4'h0, 1'b1);
        drain("t5_drain");
        check("t5_idle", 64'({i0_tready, i1_tready, o_tvalid}), 64'd0);

        // Reset in the middle of a 4-beat frame
        do_reset();
        for (int b = 0; b < 4; b++)
            push_beat(1'b0, 32'hF0000000 + 32'(b), 4'hF, b == 3);
        n = 0;
        while (acc0_cyc.size() < 2 && n < 50) begin @(posedge clk); #2; n++; end
        check("t6_two_accepted", 64'(acc0_cyc.size()), 64'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_out", 64'({o_tvalid, o_tdata, o_tkeep, o_tlast, o_src}), 64'd0);
        check("t6_rst_frame", 64'({o_frame_done, o_frame_src, o_frame_bytes, i0_tready, i1_tready}), 64'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_beat(1'b1, 32'h11111111, 4'hF, 1'b0);
        push_beat(1'b1, 32'h22222222, 4'h3, 1'b1);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qoi_axis_frame_arbiter.md
Name: qoi_axis_frame_arbiter

Overview:
- Two-requester, frame-locked, round-robin arbiter. Shares one 32-bit AXI-stream output (tdata/tkeep/tlast) between two QOI compressor instances.
- Once a source is granted, it keeps the output until its tlast beat is accepted, so frames are never interleaved.
- Has one registered output stage.
- Reports per-frame byte count and source index when each frame's last beat leaves the block. The downstream sink (file writer, DMA) can then delimit frames.

Parameters:
- INIT_PRIO, 0: port favoured at the first arbitration after reset (0 or 1).
- CNT_W, 32: width of the frame byte counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i0_tready  output  1  port-0 ready.
- i0_tvalid  input  1  port-0 valid.
- i0_tdata  input  32  port-0 data; byte k = bits [8k+7:8k].
- i0_tkeep  input  4  port-0 byte enables.
- i0_tlast  input  1  port-0 last beat of frame.
- i1_tready, i1_tvalid, i1_tdata, i1_tkeep, i1_tlast: same as port 0, for port 1.
- o_tready  input  1  downstream ready.
- o_tvalid  output  1  output valid.
- o_tdata  output  32  output data.
- o_tkeep  output  4  output byte enables.
- o_tlast  output  1  output last beat.
- o_src  output  1  source index of the beat currently on the output.
- o_frame_done  output  1  single-cycle pulse when a tlast beat is accepted at the output.
- o_frame_src  output  1  source of the finished frame; valid with o_frame_done.
- o_frame_bytes  output  CNT_W  byte count of the finished frame; valid with o_frame_done.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; pref = INIT_PRIO.
  - o_tvalid, o_tdata, o_tkeep, o_tlast, o_src = 0.
  - o_frame_done, o_frame_src, o_frame_bytes = 0; byte accumulator = 0.
  - i0_tready = i1_tready = 0.
- Asserting rst mid-frame discards the partial frame and any held output beat. No frame_done is produced for it.
- State IDLE:
  - Both iN_tready = 0.
  - If only one iN_tvalid = 1, grant that port.
  - If both are 1, grant port pref.
  - Next state is BUSY(g). This arbitration cycle accepts no data.
- State BUSY(g):
  - ig_tready = ~o_tvalid | o_tready. The non-granted port's tready = 0.
  - Input beat accepted when ig_tvalid & ig_tready. It loads the output register (tdata, tkeep, tlast, o_src = g) on the same edge.
  - If the accepted beat has tlast = 1: next state IDLE, pref = ~g.
- Output register:
  - On input accept: o_tvalid <= 1.
  - Else if o_tready: o_tvalid <= 0.
  - Else hold all output fields stable (AXI rule: no change while valid & ~ready).
- Throughput and latency:
  - Input to output latency is 1 cycle.
  - Full throughput (1 beat/cycle) within a frame.
  - One idle arbitration cycle between frames. The next frame's first beat can be accepted on the cycle after IDLE, concurrently with the previous tlast still sitting in the output register.
- Byte counting is done at the output handshake (o_tvalid & o_tready):
  - n = popcount(o_tkeep), range 0..4.
  - If o_tlast = 0: accumulator <= accumulator + n.
  - If o_tlast = 1: o_frame_bytes <= accumulator + n; o_frame_src <= o_src; o_frame_done <= 1 for one cycle; accumulator <= 0.
  - All arithmetic is modulo 2^CNT_W; wrap is silent.
- tkeep = 0 beats pass through unchanged and count 0 bytes. A tlast beat with tkeep = 0 still ends the frame.
- Sources are never throttled except through tready. tvalid from a non-granted port is ignored; no data is dropped.

Test Plan:
- Reset then single frame on port 0: 3 beats 0x04030201/0x08070605/0x0000000A, tkeep F,F,1, tlast on beat 3, o_tready = 1.
  - Output: same beats in order, 1-cycle latency, o_src = 0.
  - o_frame_done pulses once with o_frame_bytes = 9, o_frame_src = 0.
- Both ports valid continuously, 2-beat frames, INIT_PRIO = 0.
  - Output frame order is 0,1,0,1; no beat interleaving; one idle cycle between frames.
  - Each frame_done reports bytes = 8 with alternating src.
- Backpressure: o_tready toggled 1,0,0,1 during a port-1 frame.
  - o_tdata/o_tkeep/o_tlast held stable while stalled; i1_tready = 0 in the stalled cycles; no beat lost or duplicated.
- Port 1 requests while port 0 is mid-frame.
  - i1_tready stays 0 until port 0's tlast is accepted; port 1 is then granted after one IDLE cycle.
- Zero-keep tlast: beats tkeep F, then tkeep 0 with tlast.
  - o_frame_bytes = 4; state returns to IDLE.
- Reset asserted after 2 beats of a 4-beat frame.
  - All outputs become 0 immediately (async); no frame_done.
  - After release, a new port-1 frame completes normally with the correct byte count.
